// File: rtl/gelato_banked_register_file_if.sv
// Bundle of request, response and writeback signals for gelato_banked_register_file.
// master = warp scheduler / dispatch side, slave = the register file.
// Request and response use strict valid/ready: a transfer happens on a clock
// edge where valid && ready; once valid is raised the payload stays put until
// that edge. The writeback channel has no ready and is always taken.
interface gelato_banked_register_file_if #(
    parameter int WARP_NUM   = 8,
    parameter int REG_NUM    = 32,
    parameter int THREAD_NUM = 8,
    parameter int DATA_WIDTH = 32
);
    localparam int WW = $clog2(WARP_NUM);
    localparam int RW = $clog2(REG_NUM);
    localparam int LW = THREAD_NUM * DATA_WIDTH;

    logic                  req_valid;
    logic                  req_ready;
    logic [WW-1:0]         req_warp;
    logic [3*RW-1:0]       req_reg;
    logic [2:0]            req_mask;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WW-1:0]         rsp_warp;
    logic [3*LW-1:0]       rsp_data;

    logic                  wb_valid;
    logic [WW-1:0]         wb_warp;
    logic [RW-1:0]         wb_reg;
    logic [THREAD_NUM-1:0] wb_thread_mask;
    logic [LW-1:0]         wb_data;

    modport master (
        output req_valid, req_warp, req_reg, req_mask,
        input  req_ready,
        input  rsp_valid, rsp_warp, rsp_data,
        output rsp_ready,
        output wb_valid, wb_warp, wb_reg, wb_thread_mask, wb_data
    );

    modport slave (
        input  req_valid, req_warp, req_reg, req_mask,
        output req_ready,
        output rsp_valid, rsp_warp, rsp_data,
        input  rsp_ready,
        input  wb_valid, wb_warp, wb_reg, wb_thread_mask, wb_data
    );
endinterface

// File: rtl/gelato_banked_register_file.sv
// Banked register file with built-in operand collector.
// Collects up to three source operands of one warp instruction from BANK_NUM
// single-port banks; writeback always owns its bank for the cycle.
// Optional macro GELATO_RF_WB_BYPASS_EN: a pending slot matching a full-mask
// writeback takes wb_data directly instead of waiting for its bank.
// dbg_state exposes the FSM state (0 IDLE, 1 COLLECT, 2 RESP).
module gelato_banked_register_file #(
    parameter int BANK_NUM   = 4,
    parameter int WARP_NUM   = 8,
    parameter int REG_NUM    = 32,
    parameter int THREAD_NUM = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rdy,
    gelato_banked_register_file_if.slave  bus,
    output logic [1:0]                    dbg_state
);
    localparam int WW    = $clog2(WARP_NUM);
    localparam int RW    = $clog2(REG_NUM);
    localparam int LW    = THREAD_NUM * DATA_WIDTH;
    localparam int BW    = $clog2(BANK_NUM);
    localparam int ROWS  = WARP_NUM * REG_NUM / BANK_NUM;
    localparam int ROW_W = WW + RW - BW;
    localparam int SW    = ((RW > WW) ? RW : WW) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_RESP    = 2'd2
    } state_t;

    function automatic logic [BW-1:0] bank_of(input logic [WW-1:0] w, input logic [RW-1:0] r);
        logic [SW-1:0] s;
        s = SW'(r) + SW'(w);
        return s[BW-1:0];
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [WW-1:0] w, input logic [RW-1:0] r);
        logic [WW+RW-1:0] cat;
        cat = {w, r};
        return cat[WW+RW-1:BW];
    endfunction

    // Storage is deliberately not reset.
    logic [LW-1:0]    mem       [0:BANK_NUM-1][0:ROWS-1];
    logic [LW-1:0]    rd_data_q [0:BANK_NUM-1];
    logic [LW-1:0]    rd_data_d [0:BANK_NUM-1];

    state_t           state_q, state_d;
    logic [WW-1:0]    warp_q, warp_d;
    logic [3*RW-1:0]  reg_q, reg_d;
    logic [2:0]       pending_q, pending_d;
    logic [2:0]       inflight_q, inflight_d;
    logic             started_q, started_d;
    logic [3*LW-1:0]  buf_q, buf_d;

    logic             wb_en;
    logic [BW-1:0]    wb_bank;
    logic [ROW_W-1:0] wb_row;
    logic [BW-1:0]    slot_bank [0:2];
    logic [ROW_W-1:0] slot_row  [0:2];
    logic [2:0]       bypass_hit;
    logic [2:0]       issue_slot;
    logic [1:0]       arb_sel   [0:BANK_NUM-1];
    logic [BANK_NUM-1:0] rd_en;
    logic [ROW_W-1:0] rd_row    [0:BANK_NUM-1];
    logic             req_ready;

    assign wb_en   = rdy && bus.wb_valid;
    assign wb_bank = bank_of(bus.wb_warp, bus.wb_reg);
    assign wb_row  = row_of(bus.wb_warp, bus.wb_reg);

    // Bank and row of each latched source slot.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            slot_bank[k] = bank_of(warp_q, reg_q[k*RW +: RW]);
            slot_row[k]  = row_of(warp_q, reg_q[k*RW +: RW]);
        end
    end

    // Full-mask writeback forwarding into matching pending slots (optional).
    always_comb begin
        bypass_hit = 3'b000;
`ifdef GELATO_RF_WB_BYPASS_EN
        for (int k = 0; k < 3; k++) begin
            if (state_q == S_COLLECT && wb_en && pending_q[k] &&
                bus.wb_warp == warp_q && bus.wb_reg == reg_q[k*RW +: RW] &&
                (&bus.wb_thread_mask)) begin
                bypass_hit[k] = 1'b1;
            end
        end
`endif
    end

    // Per-bank arbitration: lowest pending slot wins a bank the writeback left free.
    always_comb begin
        rd_en      = '0;
        issue_slot = 3'b000;
        for (int b = 0; b < BANK_NUM; b++) begin
            arb_sel[b] = 2'd3;
            rd_row[b]  = '0;
        end
        for (int b = 0; b < BANK_NUM; b++) begin
            if (rdy && state_q == S_COLLECT && !(wb_en && wb_bank == BW'(b))) begin
                for (int k = 2; k >= 0; k--) begin
                    if (pending_q[k] && !bypass_hit[k] && slot_bank[k] == BW'(b)) begin
                        arb_sel[b] = 2'(k);
                    end
                end
                if (arb_sel[b] != 2'd3) begin
                    rd_en[b]                = 1'b1;
                    rd_row[b]               = slot_row[arb_sel[b]];
                    issue_slot[arb_sel[b]]  = 1'b1;
                end
            end
        end
    end

    // Synchronous bank read: the output register only moves on an issued read.
    always_comb begin
        for (int b = 0; b < BANK_NUM; b++) begin
            rd_data_d[b] = rd_en[b] ? mem[b][rd_row[b]] : rd_data_q[b];
        end
    end

    // FSM next state, slot bookkeeping and operand capture.
    always_comb begin
        state_d    = state_q;
        warp_d     = warp_q;
        reg_d      = reg_q;
        pending_d  = pending_q;
        inflight_d = inflight_q;
        started_d  = started_q;
        buf_d      = buf_q;
        req_ready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = rdy;
                if (rdy && bus.req_valid) begin
                    warp_d     = bus.req_warp;
                    reg_d      = bus.req_reg;
                    pending_d  = bus.req_mask;
                    inflight_d = 3'b000;
                    started_d  = 1'b0;
                    buf_d      = '0;
                    state_d    = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (rdy) begin
                    for (int k = 0; k < 3; k++) begin
                        if (inflight_q[k]) buf_d[k*LW +: LW] = rd_data_q[slot_bank[k]];
                        if (bypass_hit[k]) buf_d[k*LW +: LW] = bus.wb_data;
                    end
                    pending_d  = pending_q & ~issue_slot & ~bypass_hit;
                    inflight_d = issue_slot;
                    started_d  = 1'b1;
                    // The first COLLECT cycle always stays, so even an empty
                    // mask pays the issue-plus-return pipeline latency.
                    if (started_q && pending_d == 3'b000 && inflight_d == 3'b000) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rdy && bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and operand-buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            warp_q     <= '0;
            reg_q      <= '0;
            pending_q  <= 3'b000;
            inflight_q <= 3'b000;
            started_q  <= 1'b0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            warp_q     <= warp_d;
            reg_q      <= reg_d;
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
            started_q  <= started_d;
            buf_q      <= buf_d;
        end
    end

    // Bank read-data registers (datapath, not reset).
    always_ff @(posedge clk) begin
        for (int b = 0; b < BANK_NUM; b++) rd_data_q[b] <= rd_data_d[b];
    end

    // Writeback into the banks with per-lane enables.
    always_ff @(posedge clk) begin
        if (wb_en) begin
            for (int l = 0; l < THREAD_NUM; l++) begin
                if (bus.wb_thread_mask[l]) begin
                    mem[wb_bank][wb_row][l*DATA_WIDTH +: DATA_WIDTH] <= bus.wb_data[l*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // rsp_valid is masked by rdy so a frozen block never completes a transfer.
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rdy && (state_q == S_RESP);
    assign bus.rsp_warp  = warp_q;
    assign bus.rsp_data  = buf_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_gelato_banked_register_file.sv
// Directed self-checking bench for gelato_banked_register_file.
// Expected values are hand-computed constants; slot expectations go through exp_q.
module tb_gelato_banked_register_file;
    localparam int BANK_NUM   = 4;
    localparam int WARP_NUM   = 8;
    localparam int REG_NUM    = 32;
    localparam int THREAD_NUM = 8;
    localparam int DATA_WIDTH = 32;
    localparam int WW = $clog2(WARP_NUM);
    localparam int RW = $clog2(REG_NUM);
    localparam int LW = THREAD_NUM * DATA_WIDTH;

`ifdef GELATO_RF_WB_BYPASS_EN
    localparam int HAZARD_LAT = 2;
`else
    localparam int HAZARD_LAT = 3;
`endif

    logic       clk;
    logic       rst_n;
    logic       rdy;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [LW-1:0] exp_q[$];

    gelato_banked_register_file_if #(
        .WARP_NUM(WARP_NUM), .REG_NUM(REG_NUM),
        .THREAD_NUM(THREAD_NUM), .DATA_WIDTH(DATA_WIDTH)
    ) bus ();

    gelato_banked_register_file #(
        .BANK_NUM(BANK_NUM), .WARP_NUM(WARP_NUM), .REG_NUM(REG_NUM),
        .THREAD_NUM(THREAD_NUM), .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdy       (rdy),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and time limit
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [LW-1:0] rep(input logic [DATA_WIDTH-1:0] v);
        return {THREAD_NUM{v}};
    endfunction

    // Driver tasks
    task automatic wb_write(input int w, input int r, input logic [THREAD_NUM-1:0] m,
                            input logic [LW-1:0] d);
        bus.wb_valid       = 1'b1;
        bus.wb_warp        = WW'(w);
        bus.wb_reg         = RW'(r);
        bus.wb_thread_mask = m;
        bus.wb_data        = d;
        @(posedge clk); #1;
        bus.wb_valid       = 1'b0;
    endtask

    // Returns 1 time unit after the handshake edge.
    task automatic send_req(input int w, input int r0, input int r1, input int r2,
                            input logic [2:0] m);
        int n;
        bus.req_valid = 1'b1;
        bus.req_warp  = WW'(w);
        bus.req_reg   = {RW'(r2), RW'(r1), RW'(r0)};
        bus.req_mask  = m;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL req_handshake_timeout: req_ready=%b after %0d cycles, required 1", bus.req_ready, n);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int lat0, output int lat);
        lat = lat0;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (!bus.rsp_valid) begin
            failures++;
            $display("FAIL rsp_timeout: rsp_valid=0 after %0d cycles, required 1", lat);
        end
    endtask

    task automatic accept_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        rdy   = 1'b1;
        bus.req_valid = 1'b0; bus.req_warp = '0; bus.req_reg = '0; bus.req_mask = '0;
        bus.rsp_ready = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_warp = '0; bus.wb_reg = '0;
        bus.wb_thread_mask = '0; bus.wb_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            failures++; $display("FAIL reset_rsp_valid_in_reset: got %b required 0", bus.rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++; $display("FAIL reset_req_ready: got %b required 1", bus.req_ready);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            failures++; $display("FAIL reset_rsp_valid: got %b required 0", bus.rsp_valid);
        end
        checks++;
        if (bus.rsp_warp !== '0) begin
            failures++; $display("FAIL reset_rsp_warp: got %0d required 0", bus.rsp_warp);
        end
        checks++;
        if (bus.rsp_data !== '0) begin
            failures++; $display("FAIL reset_rsp_data: got nonzero required 0");
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            failures++; $display("FAIL reset_state: got %0d required 0", dbg_state);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [LW-1:0] exp;
        wb_write(0, 1, '1, rep(32'h11));
        wb_write(0, 2, '1, rep(32'h22));
        wb_write(0, 3, '1, rep(32'h33));
        send_req(0, 1, 2, 3, 3'b111);
        wait_rsp(0, lat);
        checks++;
        if (lat != 2) begin
            failures++; $display("FAIL basic_latency: got %0d cycles required 2", lat);
        end
        checks++;
        if (bus.rsp_warp !== WW'(0)) begin
            failures++; $display("FAIL basic_rsp_warp: got %0d required 0", bus.rsp_warp);
        end
        exp_q.push_back(rep(32'h11));
        exp_q.push_back(rep(32'h22));
        exp_q.push_back(rep(32'h33));
        for (int k = 0; k < 3; k++) begin
            exp = exp_q.pop_front();
            checks++;
            if (bus.rsp_data[k*LW +: LW] !== exp) begin
                failures++;
                $display("FAIL basic_slot%0d: got %h required %h", k, bus.rsp_data[k*LW +: LW], exp);
            end
        end
        accept_rsp();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_after_accept: rsp_valid=%b req_ready=%b required 0/1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_empty_mask();
        int lat;
        send_req(3, 1, 2, 3, 3'b000);
        wait_rsp(0, lat);
        checks++;
        if (lat != 2) begin
            failures++; $display("FAIL empty_latency: got %0d cycles required 2", lat);
        end
        checks++;
        if (bus.rsp_data !== '0) begin
            failures++; $display("FAIL empty_data: got nonzero operand buffer required 0");
        end
        checks++;
        if (bus.rsp_warp !== WW'(3)) begin
            failures++; $display("FAIL empty_rsp_warp: got %0d required 3", bus.rsp_warp);
        end
        accept_rsp();
    endtask

    task automatic test_conflict();
        int lat;
        logic [LW-1:0] exp;
        wb_write(0, 0, '1, rep(32'hA0));
        wb_write(0, 4, '1, rep(32'hA4));
        wb_write(0, 8, '1, rep(32'hA8));
        send_req(0, 0, 4, 8, 3'b111);
        wait_rsp(0, lat);
        checks++;
        if (lat != 4) begin
            failures++; $display("FAIL conflict_latency: got %0d cycles required 4", lat);
        end
        exp_q.push_back(rep(32'hA0));
        exp_q.push_back(rep(32'hA4));
        exp_q.push_back(rep(32'hA8));
        for (int k = 0; k < 3; k++) begin
            exp = exp_q.pop_front();
            checks++;
            if (bus.rsp_data[k*LW +: LW] !== exp) begin
                failures++;
                $display("FAIL conflict_slot%0d: got %h required %h", k, bus.rsp_data[k*LW +: LW], exp);
            end
        end
        accept_rsp();
    endtask

    task automatic test_wb_hazard();
        int lat;
        logic [LW-1:0] exp;
        wb_write(1, 3, '1, rep(32'h55));
        send_req(1, 3, 0, 0, 3'b001);
        // Writeback to the same register during the first COLLECT cycle.
        bus.wb_valid       = 1'b1;
        bus.wb_warp        = WW'(1);
        bus.wb_reg         = RW'(3);
        bus.wb_thread_mask = '1;
        bus.wb_data        = rep(32'hAB);
        @(posedge clk); #1;
        bus.wb_valid       = 1'b0;
        wait_rsp(1, lat);
        checks++;
        if (lat != HAZARD_LAT) begin
            failures++; $display("FAIL hazard_latency: got %0d cycles required %0d", lat, HAZARD_LAT);
        end
        exp_q.push_back(rep(32'hAB));
        exp_q.push_back('0);
        exp_q.push_back('0);
        for (int k = 0; k < 3; k++) begin
            exp = exp_q.pop_front();
            checks++;
            if (bus.rsp_data[k*LW +: LW] !== exp) begin
                failures++;
                $display("FAIL hazard_slot%0d: got %h required %h", k, bus.rsp_data[k*LW +: LW], exp);
            end
        end
        accept_rsp();
    endtask

    task automatic test_partial();
        int lat;
        logic [LW-1:0] exp;
        wb_write(2, 5, '1, rep(32'hFFFF_FFFF));
        wb_write(2, 5, 8'h0F, '0);
        send_req(2, 0, 5, 0, 3'b010);
        wait_rsp(0, lat);
        checks++;
        if (lat != 2) begin
            failures++; $display("FAIL partial_latency: got %0d cycles required 2", lat);
        end
        exp_q.push_back('0);
        exp_q.push_back({{4{32'hFFFF_FFFF}}, {4{32'h0}}});
        exp_q.push_back('0);
        for (int k = 0; k < 3; k++) begin
            exp = exp_q.pop_front();
            checks++;
            if (bus.rsp_data[k*LW +: LW] !== exp) begin
                failures++;
                $display("FAIL partial_slot%0d: got %h required %h", k, bus.rsp_data[k*LW +: LW], exp);
            end
        end
        accept_rsp();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [3*LW-1:0] exp_all;
        exp_all = {rep(32'h33), rep(32'h22), rep(32'h11)};
        send_req(0, 1, 2, 3, 3'b111);
        wait_rsp(0, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_handshake cycle%0d: rsp_valid=%b req_ready=%b required 1/0", i, bus.rsp_valid, bus.req_ready);
            end
            checks++;
            if (bus.rsp_data !== exp_all) begin
                failures++;
                $display("FAIL hold_data cycle%0d: got %h required %h", i, bus.rsp_data, exp_all);
            end
        end
        accept_rsp();
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            failures++; $display("FAIL hold_release: rsp_valid=%b required 0", bus.rsp_valid);
        end
    endtask

    task automatic test_stall();
        int lat;
        logic [LW-1:0] exp;
        send_req(0, 1, 2, 3, 3'b111);
        // Freeze for 3 cycles; the writeback offered meanwhile must be dropped.
        rdy                = 1'b0;
        bus.wb_valid       = 1'b1;
        bus.wb_warp        = WW'(0);
        bus.wb_reg         = RW'(1);
        bus.wb_thread_mask = '1;
        bus.wb_data        = rep(32'h99);
        lat = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            lat++;
            checks++;
            if (bus.rsp_valid !== 1'b0 || dbg_state !== 2'd1) begin
                failures++;
                $display("FAIL stall_frozen cycle%0d: rsp_valid=%b state=%0d required 0/1", i, bus.rsp_valid, dbg_state);
            end
        end
        rdy          = 1'b1;
        bus.wb_valid = 1'b0;
        wait_rsp(lat, lat);
        checks++;
        if (lat != 5) begin
            failures++; $display("FAIL stall_latency: got %0d cycles required 5", lat);
        end
        exp_q.push_back(rep(32'h11));
        exp_q.push_back(rep(32'h22));
        exp_q.push_back(rep(32'h33));
        for (int k = 0; k < 3; k++) begin
            exp = exp_q.pop_front();
            checks++;
            if (bus.rsp_data[k*LW +: LW] !== exp) begin
                failures++;
                $display("FAIL stall_slot%0d: got %h required %h", k, bus.rsp_data[k*LW +: LW], exp);
            end
        end
        accept_rsp();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [LW-1:0] exp;
        send_req(0, 1, 2, 3, 3'b111);
        rst_n = 1'b0;
        #2;
        checks++;
        if (bus.rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL midreset_async: rsp_valid=%b state=%0d required 0/0", bus.rsp_valid, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_release: req_ready=%b rsp_valid=%b required 1/0", bus.req_ready, bus.rsp_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                failures++; $display("FAIL midreset_no_rsp cycle%0d: rsp_valid=%b required 0", i, bus.rsp_valid);
            end
        end
        send_req(0, 3, 2, 1, 3'b111);
        wait_rsp(0, lat);
        checks++;
        if (lat != 2) begin
            failures++; $display("FAIL midreset_new_latency: got %0d cycles required 2", lat);
        end
        exp_q.push_back(rep(32'h33));
        exp_q.push_back(rep(32'h22));
        exp_q.push_back(rep(32'h11));
        for (int k = 0; k < 3; k++) begin
            exp = exp_q.pop_front();
            checks++;
            if (bus.rsp_data[k*LW +: LW] !== exp) begin
                failures++;
                $display("FAIL midreset_slot%0d: got %h required %h", k, bus.rsp_data[k*LW +: LW], exp);
            end
        end
        accept_rsp();
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_basic();
        test_empty_mask();
        test_conflict();
        test_wb_hazard();
        test_partial();
        test_backpressure();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gelato_banked_register_file.md
Name: gelato_banked_register_file

Overview:
- Parametrised successor of the Gelato banked register file.
- Operand collection, bank arbitration and writeback are folded into one block with flat valid/ready ports.
- Gathers up to 3 source operands for one warp instruction across BANK_NUM single-port banks, serialising bank conflicts over multiple cycles.
- Writeback always has bank priority. Sits between the warp scheduler issue stage and the execution dispatch.

Parameters:
- BANK_NUM, 4: number of single-port banks; power of 2, at least 2.
- WARP_NUM, 8: warps; power of 2.
- REG_NUM, 32: architectural registers per warp; multiple of BANK_NUM.
- THREAD_NUM, 8: lanes per warp.
- DATA_WIDTH, 32: bits per lane.
- Derived: WW = log2(WARP_NUM), RW = log2(REG_NUM), LW = THREAD_NUM*DATA_WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; when 0 all state holds and no bank access occurs
- req_valid  in  1  operand request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_warp  in  WW  warp id
- req_reg  in  3*RW  source register ids; slot k at [k*RW +: RW]
- req_mask  in  3  slot k used
- rsp_valid  out  1  collected operands valid
- rsp_ready  in  1  consumer accepts
- rsp_warp  out  WW  warp id of response
- rsp_data  out  3*LW  operand slot k at [k*LW +: LW]; unused slots are 0
- wb_valid  in  1  writeback valid; always accepted, no ready
- wb_warp  in  WW  writeback warp
- wb_reg  in  RW  writeback register
- wb_thread_mask  in  THREAD_NUM  lanes written
- wb_data  in  LW  writeback data

Behaviour:
- Mapping: bank = (reg + warp) mod BANK_NUM; row = {warp, reg / BANK_NUM}. Each bank does one access per cycle, either read or write.
- Storage is not reset. Bench writes before reading.
- Writeback:
  - When rdy && wb_valid, lanes with mask=1 are written at the clock edge; other lanes are unchanged.
  - Writeback wins its bank unconditionally.
- FSM states: IDLE, COLLECT, RESP. Reset gives IDLE, pending=0, inflight=0, rsp_valid=0, rsp_warp=0, rsp_data=0.
- IDLE:
  - req_ready = rdy. Handshake latches warp, regs and mask, sets pending = req_mask, clears the operand buffer, then goes to COLLECT.
- COLLECT:
  - For each bank not targeted by this cycle's writeback, select the lowest-index pending slot mapped to it and issue a read.
  - Clear that pending bit and set inflight. Read data returns the next cycle and is captured into its slot.
  - Exit to RESP when pending=0 and inflight=0. Minimum latency from handshake to rsp_valid is 2 cycles with no conflicts (mask=0 also takes 2 cycles).
  - Two slots on the same bank take one extra cycle each. Identical registers in two slots are still read separately.
- RESP:
  - rsp_valid=1 and rsp_data stable until rsp_ready, then go to IDLE and drop rsp_valid.
  - req_ready=0 in all non-IDLE states.
- Hazards:
  - A read issued in cycle t observes every write committed before edge t.
  - A read deferred by a writeback to the same register sees the new value.
  - Writes after a slot's read issue do not alter the captured operand.
- rdy=0 freezes the FSM, pending, inflight and buffers. Writebacks presented while rdy=0 are dropped.
- Asynchronous reset mid-COLLECT or RESP discards the request and returns to IDLE with outputs at reset values.

Optional Feature:
- Macro GELATO_RF_WB_BYPASS_EN.
- Defined: in COLLECT, a pending slot whose warp and register equal the writeback's and whose wb_thread_mask is all ones captures wb_data directly that cycle and clears its pending bit, without needing its bank. A partial mask still defers the slot.
- Undefined: no forwarding; behaviour exactly as above.

Test Plan:
- Write w0 r1=0x11 in all lanes, w0 r2=0x22, w0 r3=0x33. Request warp0 regs {1,2,3} with mask 111. Expect rsp_valid 2 cycles after handshake with slots 0x11, 0x22, 0x33.
- Conflict: request warp0 regs {0,4,8}, all in bank 0, with BANK_NUM=4. Expect rsp_valid 4 cycles after handshake and correct values.
- Request warp1 r3 (bank 0) while holding wb to warp1 r3 with 0xAB and full mask in the first COLLECT cycle. The read is deferred and the response returns 0xAB. With the macro defined, latency drops by 1.
- Partial write: w2 r5 set to 0xFFFFFFFF on all lanes, then mask 0x0F with data 0. Read returns lanes 0-3 = 0 and lanes 4-7 = 0xFFFFFFFF.
- Hold rsp_ready=0 for 5 cycles with rsp_valid high. Data stays stable and req_ready stays 0. Pulse rdy=0 mid-COLLECT and latency extends by the stall length.
- Assert rst_n=0 mid-COLLECT. rsp_valid stays 0 and req_ready=1 on the first cycle after release; a new request then completes normally.
